// File: rtl/cv32e40p_fpu_issue_queue.sv
// cv32e40p_fpu_issue_queue: in-order FP request buffer with DIV/SQRT serialisation and illegal-encoding discard
module cv32e40p_fpu_issue_queue #(
    parameter int DEPTH     = 2,
    parameter int C_FLEN    = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [3:0]              in_op_i,
    input  logic                    in_op_mod_i,
    input  logic [2:0]              in_src_fmt_i,
    input  logic [2:0]              in_dst_fmt_i,
    input  logic [1:0]              in_int_fmt_i,
    input  logic [2:0]              in_rnd_i,
    input  logic [3*C_FLEN-1:0]     in_operands_i,
    input  logic [TAG_WIDTH-1:0]    in_tag_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [3:0]              out_op_o,
    output logic                    out_op_mod_o,
    output logic [2:0]              out_src_fmt_o,
    output logic [2:0]              out_dst_fmt_o,
    output logic [1:0]              out_int_fmt_o,
    output logic [2:0]              out_rnd_o,
    output logic [3*C_FLEN-1:0]     out_operands_o,
    output logic [TAG_WIDTH-1:0]    out_tag_o,
    input  logic                    divsqrt_done_i,
    output logic                    divsqrt_busy_o,
    output logic                    illegal_o,
    output logic [$clog2(DEPTH):0]  count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 16 + 3 * C_FLEN + TAG_WIDTH;
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_SQRT = 4'd5;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          illegal, push, pop, head_ds, busy;

    assign illegal = (in_op_i == 4'd15) || (in_src_fmt_i > 3'd4) || (in_dst_fmt_i > 3'd4);
    assign in_ready_o = (count != FULL) && !flush_i;
    assign push = in_valid_i && in_ready_o && !illegal;
    assign {out_op_o, out_op_mod_o, out_src_fmt_o, out_dst_fmt_o, out_int_fmt_o,
            out_rnd_o, out_operands_o, out_tag_o} = mem[rptr];
    assign head_ds = (out_op_o == OP_DIV) || (out_op_o == OP_SQRT);
    assign out_valid_o = (count != '0) && !(head_ds && busy);
    assign pop = out_valid_o && out_ready_i && !flush_i;
    assign divsqrt_busy_o = busy;
    assign count_o = count;

    // Entry storage; only legal requests are written
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= {in_op_i, in_op_mod_i, in_src_fmt_i, in_dst_fmt_i, in_int_fmt_i,
                          in_rnd_i, in_operands_i, in_tag_i};
    end

    // Pointers and occupancy; flush empties the queue but leaves the DIV/SQRT unit running
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= push ? wptr + AW'(1) : wptr;
            rptr  <= pop ? rptr + AW'(1) : rptr;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end

    // DIV/SQRT occupancy: issuing wins over a coincident completion
    always_ff @(posedge clk) begin
        if (rst)
            busy <= 1'b0;
        else if (pop && head_ds)
            busy <= 1'b1;
        else if (divsqrt_done_i)
            busy <= 1'b0;
    end

    // Discard notification, one cycle after an illegal request is handshaken
    always_ff @(posedge clk) begin
        illegal_o <= rst ? 1'b0 : (in_valid_i && in_ready_o && illegal);
    end
endmodule

// File: tb/tb_cv32e40p_fpu_issue_queue.sv
// tb_cv32e40p_fpu_issue_queue: scoreboard bench with a queue-based reference model
module tb_cv32e40p_fpu_issue_queue;
    localparam int DEPTH = 2;
    localparam int FL = 32;
    localparam int TW = 5;

    typedef struct packed {
        logic [3:0]      op;
        logic            mod;
        logic [2:0]      src;
        logic [2:0]      dst;
        logic [1:0]      ifmt;
        logic [2:0]      rnd;
        logic [3*FL-1:0] opnds;
        logic [TW-1:0]   tag;
    } req_t;

    logic clk, rst, flush_i, in_valid_i, in_ready_o, in_op_mod_i, out_valid_o, out_ready_i;
    logic divsqrt_done_i, divsqrt_busy_o, illegal_o, out_op_mod_o;
    logic [3:0] in_op_i, out_op_o;
    logic [2:0] in_src_fmt_i, in_dst_fmt_i, in_rnd_i, out_src_fmt_o, out_dst_fmt_o, out_rnd_o;
    logic [1:0] in_int_fmt_i, out_int_fmt_o;
    logic [3*FL-1:0] in_operands_i, out_operands_o;
    logic [TW-1:0] in_tag_i, out_tag_o;
    logic [$clog2(DEPTH):0] count_o;

    cv32e40p_fpu_issue_queue #(.DEPTH(DEPTH), .C_FLEN(FL), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_op_i(in_op_i),
        .in_op_mod_i(in_op_mod_i), .in_src_fmt_i(in_src_fmt_i), .in_dst_fmt_i(in_dst_fmt_i),
        .in_int_fmt_i(in_int_fmt_i), .in_rnd_i(in_rnd_i), .in_operands_i(in_operands_i),
        .in_tag_i(in_tag_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_op_o(out_op_o), .out_op_mod_o(out_op_mod_o), .out_src_fmt_o(out_src_fmt_o),
        .out_dst_fmt_o(out_dst_fmt_o), .out_int_fmt_o(out_int_fmt_o), .out_rnd_o(out_rnd_o),
        .out_operands_o(out_operands_o), .out_tag_o(out_tag_o),
        .divsqrt_done_i(divsqrt_done_i), .divsqrt_busy_o(divsqrt_busy_o),
        .illegal_o(illegal_o), .count_o(count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    req_t exp_q[$];
    logic m_busy = 1'b0;
    logic m_ill = 1'b0;
    logic m_ready = 1'b1;
    logic ordy = 1'b0, done = 1'b0, fl = 1'b0, rs = 1'b1;

    task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    endtask

    function automatic logic is_ill(input req_t r);
        return (r.op == 4'd15) || (r.src > 3'd4) || (r.dst > 3'd4);
    endfunction

    function automatic logic is_ds(input req_t r);
        return (r.op == 4'd4) || (r.op == 4'd5);
    endfunction

    function automatic req_t mk(input int op, input int src, input int dst, input int tag);
        req_t r;
        r = '0;
        r.op = 4'(op);
        r.src = 3'(src);
        r.dst = 3'(dst);
        r.tag = TW'(tag);
        r.opnds = {$urandom, $urandom, $urandom};
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        r = mk($urandom_range(0, 14), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 31));
        r.mod = 1'($urandom);
        r.ifmt = 2'($urandom);
        r.rnd = 3'($urandom);
        if ($urandom_range(0, 5) == 0) r.op = 4'(4 + $urandom_range(0, 1));
        case ($urandom_range(0, 15))
            0: r.op = 4'd15;
            1: r.src = 3'($urandom_range(5, 7));
            2: r.dst = 3'($urandom_range(5, 7));
            default: ;
        endcase
        return r;
    endfunction

    // One cycle of stimulus; the expected entry is queued when the model says it was taken
    task automatic step(input logic v, input req_t r, output logic acc);
        @(posedge clk);
        #1;
        rst = rs;
        flush_i = fl;
        out_ready_i = ordy;
        divsqrt_done_i = done;
        in_valid_i = v;
        {in_op_i, in_op_mod_i, in_src_fmt_i, in_dst_fmt_i, in_int_fmt_i, in_rnd_i, in_operands_i, in_tag_i} = r;
        @(negedge clk);
        #1;
        acc = v && m_ready && !rs;
        if (acc) begin
            if (is_ill(r)) m_ill = 1'b1;
            else exp_q.push_back(r);
        end
    endtask

    // Monitor: compares DUT state with the model and retires issued requests
    initial begin
        req_t h;
        logic m_valid, pop_ds;
        forever begin
            @(negedge clk);
            m_ready = (exp_q.size() != DEPTH) && !flush_i;
            m_valid = (exp_q.size() != 0) && !(is_ds(exp_q[0]) && m_busy);
            chk("in_ready", 128'(in_ready_o), 128'(m_ready));
            chk("out_valid", 128'(out_valid_o), 128'(m_valid));
            chk("count", 128'(count_o), 128'(exp_q.size()));
            chk("busy", 128'(divsqrt_busy_o), 128'(m_busy));
            chk("illegal", 128'(illegal_o), 128'(m_ill));
            m_ill = 1'b0;
            pop_ds = 1'b0;
            if (exp_q.size() != 0) begin
                h = {out_op_o, out_op_mod_o, out_src_fmt_o, out_dst_fmt_o, out_int_fmt_o,
                     out_rnd_o, out_operands_o, out_tag_o};
                chk("head", 128'(h), 128'(exp_q[0]));
            end
            if (m_valid && out_ready_i && !flush_i && !rst) begin
                pop_ds = is_ds(exp_q[0]);
                void'(exp_q.pop_front());
            end
            m_busy = rst ? 1'b0 : pop_ds ? 1'b1 : divsqrt_done_i ? 1'b0 : m_busy;
            if (rst || flush_i) exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        int n;
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; divsqrt_done_i = 1'b0;
        {in_op_i, in_op_mod_i, in_src_fmt_i, in_dst_fmt_i, in_int_fmt_i, in_rnd_i, in_operands_i, in_tag_i} = '0;
        repeat (2) step(0, mk(0, 0, 0, 0), acc);
        rs = 1'b0;
        step(0, mk(0, 0, 0, 0), acc);
        // basic flow
        ordy = 1'b1;
        step(1, mk(2, 0, 0, 3), acc);
        step(1, mk(3, 0, 0, 4), acc);
        repeat (3) step(0, mk(0, 0, 0, 0), acc);
        // full and backpressure
        ordy = 1'b0;
        step(1, mk(2, 0, 0, 5), acc);
        step(1, mk(3, 0, 0, 6), acc);
        step(1, mk(0, 0, 0, 7), acc);
        ordy = 1'b1;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 10) begin
            step(1, mk(0, 0, 0, 7), acc);
            n++;
        end
        chk("third_accepted", 128'(acc), 128'(1));
        repeat (3) step(0, mk(0, 0, 0, 0), acc);
        // DIV/SQRT serialisation
        step(1, mk(4, 0, 0, 1), acc);
        step(1, mk(5, 0, 0, 2), acc);
        repeat (6) step(0, mk(0, 0, 0, 0), acc);
        done = 1'b1;
        step(0, mk(0, 0, 0, 0), acc);
        done = 1'b0;
        repeat (3) step(0, mk(0, 0, 0, 0), acc);
        done = 1'b1;
        step(0, mk(0, 0, 0, 0), acc);
        done = 1'b0;
        // illegal discard
        step(1, mk(15, 0, 0, 9), acc);
        step(1, mk(2, 0, 6, 10), acc);
        repeat (2) step(0, mk(0, 0, 0, 0), acc);
        // flush with busy unit and a full queue
        step(1, mk(4, 0, 0, 11), acc);
        step(0, mk(0, 0, 0, 0), acc);
        ordy = 1'b0;
        step(1, mk(2, 0, 0, 12), acc);
        step(1, mk(3, 0, 0, 13), acc);
        fl = 1'b1;
        ordy = 1'b1;
        step(1, mk(2, 0, 0, 14), acc);
        fl = 1'b0;
        step(0, mk(0, 0, 0, 0), acc);
        // reset mid-traffic with busy unit and full queue
        ordy = 1'b0;
        step(1, mk(2, 0, 0, 15), acc);
        step(1, mk(3, 0, 0, 16), acc);
        rs = 1'b1;
        step(1, mk(2, 0, 0, 17), acc);
        rs = 1'b0;
        step(0, mk(0, 0, 0, 0), acc);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            ordy = ($urandom_range(0, 3) != 0);
            done = m_busy && ($urandom_range(0, 5) == 0);
            fl = ($urandom_range(0, 40) == 0);
            rs = ($urandom_range(0, 150) == 0);
            step(1'($urandom_range(0, 2) != 0), rnd_req(), acc);
        end
        fl = 1'b0; rs = 1'b0; ordy = 1'b1;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || m_busy); i++) begin
            done = m_busy && (i % 4 == 3);
            step(0, mk(0, 0, 0, 0), acc);
        end
        done = 1'b0;
        step(0, mk(0, 0, 0, 0), acc);
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
        chk("drain_busy", 128'(m_busy), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cv32e40p_fpu_issue_queue.md
# cv32e40p_fpu_issue_queue

Request queue between the core's FP decode/EX stage and the FPnew-based FPU. Buffers up to DEPTH fully decoded FP requests (operation, formats, rounding mode, operands, tag) encoded with the FPU package types. Presents requests in order to the FPU over a valid/ready handshake. Serialises the single DIV/SQRT unit and discards requests whose encodings the FPU does not define.

## Interface
Parameters:
- DEPTH, 2: queue entries; power of two, ≥2.
- C_FLEN, 32: operand width.
- TAG_WIDTH, 5: request tag width (destination register id).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush_i  in  1  drop all queued entries.
- in_valid_i  in  1  upstream request valid.
- in_ready_o  out  1  queue can accept.
- in_op_i  in  4  operation_e (FMADD=0 … CPKCD=14).
- in_op_mod_i  in  1  operation modifier.
- in_src_fmt_i, in_dst_fmt_i  in  3 each  fp_format_e (FP32=0 … FP16ALT=4).
- in_int_fmt_i  in  2  int_format_e.
- in_rnd_i  in  3  rounding mode.
- in_operands_i  in  3*C_FLEN  operands a,b,c; a in LSBs.
- in_tag_i  in  TAG_WIDTH  request tag.
- out_valid_o  out  1  head request valid to FPU.
- out_ready_i  in  1  FPU accepts.
- out_op_o, out_op_mod_o, out_src_fmt_o, out_dst_fmt_o, out_int_fmt_o, out_rnd_o, out_operands_o, out_tag_o  out  widths as inputs  head-entry fields.
- divsqrt_done_i  in  1  single-cycle pulse: DIV/SQRT unit finished.
- divsqrt_busy_o  out  1  a DIV/SQRT is in flight.
- illegal_o  out  1  one-cycle pulse: a request was discarded.
- count_o  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Circular buffer: write pointer, read pointer, occupancy counter. Pointers wrap modulo DEPTH.
- Push happens when in_valid_i && in_ready_o && the request is legal.
- in_ready_o = (count_o != DEPTH) && !flush_i. Ready never depends on out_ready_i, and there is no combinational path from input to output.
- Illegal requests have in_op_i == 15, src_fmt > 4, or dst_fmt > 4. They are still handshaken (accepted) but are not stored. illegal_o is 1 in the following cycle.
- Head stall rule: out_valid_o = !empty && !(head op ∈ {DIV, SQRT} && divsqrt_busy_o). Output fields always show the head entry, valid or not.
- Pop happens when out_valid_o && out_ready_i.
- divsqrt_busy_o:
  - Set on a pop of DIV or SQRT.
  - Cleared by divsqrt_done_i.
  - If set and done occur in the same cycle, the result is 1 (a new op issued as the old one completes; this cannot occur with the stall rule but is defined anyway).
- Flush: count and pointers reset to 0 on the next edge. A pop or push in the flush cycle is ignored; out_ready_i has no effect. divsqrt_busy_o is NOT cleared by flush, because the unit is still computing.
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, no push occurs even if a pop happens in that cycle.

## Timing
- Reset values: out_valid_o=0, in_ready_o=1 (count 0, flush low), count_o=0, divsqrt_busy_o=0, illegal_o=0, pointers=0.
- Latency: a request pushed at edge N appears at out_valid_o in the cycle after edge N, which is a minimum 1-cycle latency. There is no empty-queue bypass.
- Throughput: 1 request/cycle when neither side stalls.
- A head DIV/SQRT becomes valid in the first cycle after the edge on which divsqrt_done_i was sampled.
- Rst asserted mid-operation overrides everything: the queue is empty and busy cleared on the next edge.
- Once out_valid_o is asserted it stays asserted with stable fields until popped. Only flush or rst may withdraw it.

## Test plan
- Basic flow: push FP32 ADD tag 3, then MUL tag 4, with out_ready_i=1. Required: out_valid_o high one cycle after each push; tags emerge 3 then 4; count_o returns to 0.
- Full/backpressure: out_ready_i=0, DEPTH=2, push 3 requests. Required: third request sees in_ready_o=0 and count_o=2. Release out_ready_i. Required: order preserved, and the third request is accepted only after count drops.
- DIV serialisation: push DIV tag 1 then SQRT tag 2, out_ready_i=1. Required: tag 1 issues and busy=1; tag 2 is held with out_valid_o=0. Pulse divsqrt_done_i at cycle 10. Required: tag 2 issues at cycle 11.
- Illegal discard: push op=15, then push FP32 op with dst_fmt=6. Required: both accepted, illegal_o pulses once per request, count_o stays 0, out_valid_o stays 0.
- Flush: queue holds 2 entries and busy=1; assert flush_i with in_valid_i=1. Required: next cycle count_o=0, out_valid_o=0, busy still 1, and the input in the flush cycle is not stored.
- Reset mid-traffic: assert rst with the queue full and busy=1. Required: next cycle all outputs are at their reset values.
